// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
// Phases run RE (rising strobe), RL, FE (falling strobe), FL within each step.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] PH_RE = 2'd0;
    localparam logic [1:0] PH_RL = 2'd1;
    localparam logic [1:0] PH_FE = 2'd2;
    localparam logic [1:0] PH_FL = 2'd3;

    // Serial add keeps its carry in the ALU state register between bits.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;

endpackage

// File: rtl/alu_phase_gen.sv
// Four-phase step generator: 2-bit phase counter with registered ALU strobes.
// en describes the next cycle; a fresh enable always starts at PH_RE.
module alu_phase_gen
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic last,
    output logic reclk_strobe,
    output logic feclk_strobe
);

    logic       en_q;
    logic [1:0] phase;
    logic [1:0] phase_next;

    always_comb begin
        phase_next = PH_RE;
        if (en && en_q) begin
            phase_next = phase + 2'd1;
        end
    end

    // Strobes are decoded from the next phase so they line up with it as registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q         <= 1'b0;
            phase        <= PH_RE;
            reclk_strobe <= 1'b0;
            feclk_strobe <= 1'b0;
        end else begin
            en_q         <= en;
            phase        <= phase_next;
            reclk_strobe <= en && (phase_next == PH_RE);
            feclk_strobe <= en && (phase_next == PH_FE);
        end
    end

    assign last = en_q && (phase == PH_FL);

endmodule

// File: rtl/alu_serial_sequencer.sv
// Drives a bit-serial 1-bit ALU over WIDTH-bit operands, LSB first,
// one four-phase step per bit after a four-phase register clear.
module alu_serial_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             reclk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             alu_ain,
    output logic             alu_bin,
    output logic [2:0]       alu_op,
    output logic             alu_rst,
    output logic             alu_reclk,
    output logic             alu_feclk,
    input  logic             alu_aluout,
    input  logic             alu_regout
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    state_t           state;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             last;
    logic             accept;
    logic             finish;
    logic             phase_en;

    always_comb begin
        accept   = (state == IDLE) && start;
        finish   = (state == RUN) && last && (bit_idx == IDX_W'(WIDTH - 1));
        phase_en = accept || (((state == CLEAR) || (state == RUN)) && !finish);
    end

    alu_phase_gen u_phase (
        .clk          (reclk),
        .rst          (rst),
        .en           (phase_en),
        .last         (last),
        .reclk_strobe (alu_reclk),
        .feclk_strobe (alu_feclk)
    );

    always_ff @(posedge reclk) begin
        if (rst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            alu_ain   <= 1'b0;
            alu_bin   <= 1'b0;
            alu_op    <= '0;
            alu_rst   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh      <= a_in;
                        b_sh      <= b_in;
                        alu_op    <= opcode;
                        alu_ain   <= a_in[0];
                        alu_bin   <= b_in[0];
                        alu_rst   <= 1'b1;
                        result    <= '0;
                        carry_out <= 1'b0;
                        busy      <= 1'b1;
                        bit_idx   <= '0;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (last) begin
                        alu_rst <= 1'b0;
                        bit_idx <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (last) begin
                        result <= {alu_aluout, result[WIDTH-1:1]};
                        if (bit_idx == IDX_W'(WIDTH - 1)) begin
                            carry_out <= alu_regout;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            // Next operand bits are presented as the next PH_RE is entered.
                            a_sh    <= a_sh >> 1;
                            b_sh    <= b_sh >> 1;
                            alu_ain <= a_sh[1];
                            alu_bin <= b_sh[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
- Sequences the bit-serial 1-bit ALU over WIDTH-bit operands, one bit per four-phase step, LSB first.
- Drives the ALU's reset, its rising-edge strobe (alu_reclk) and falling-edge strobe (alu_feclk) from a single system clock.
- Shifts the ALU output into a parallel result register and reports completion with a done pulse.
- Sits between the host datapath and the alu instance; it is the only driver of the ALU inputs.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).

Ports:
- reclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  3  ALU operation; latched at accept.
- a_in  in  WIDTH  operand A; latched at accept.
- b_in  in  WIDTH  operand B; latched at accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  serial result; holds until the next accept.
- carry_out  out  1  alu_regout sampled with the final bit.
- alu_ain  out  1  current A bit to the ALU.
- alu_bin  out  1  current B bit to the ALU.
- alu_op  out  3  latched opcode.
- alu_rst  out  1  ALU register clear.
- alu_reclk  out  1  ALU rising-edge strobe.
- alu_feclk  out  1  ALU falling-edge strobe.
- alu_aluout  in  1  ALU combinational output.
- alu_regout  in  1  ALU state register output.

Behaviour:
- Interface: one clock (reclk); rst is synchronous, active-high.
- Reset: every output is 0. State is IDLE, phase counter 0, bit index 0.
- Registered outputs: all outputs are registered. Cycle k=1 is the first cycle after the accept edge.
- States: IDLE, CLEAR, RUN, DONE. A 2-bit phase counter p runs 0..3 inside CLEAR and RUN.
- Phase encoding:
  - p=0: alu_reclk=1.
  - p=1: both strobes 0.
  - p=2: alu_feclk=1.
  - p=3: both strobes 0.
  - The two strobes are never high in the same cycle.
- IDLE: if start=1, latch a_in, b_in and opcode, then go to CLEAR with p=0.
- CLEAR (k=1..4):
  - alu_rst=1 throughout.
  - alu_ain and alu_bin carry bit 0; the ALU output is ignored.
  - After p=3, go to RUN with i=0.
- RUN, bit i (k=5+4i..8+4i):
  - alu_rst=0; alu_ain=A[i], alu_bin=B[i].
  - On the edge that ends p=3, result <= {alu_aluout, result[WIDTH-1:1]}.
  - If i=WIDTH-1, also capture carry_out <= alu_regout and go to DONE; otherwise i <= i+1.
- DONE (k=4WIDTH+5): done=1, busy=0, all strobes 0. The next state is unconditionally IDLE.
- busy is high for k=1..4WIDTH+4.
- Latency: accept to done is 4WIDTH+5 cycles (37 for WIDTH=8). Minimum accept-to-accept spacing is 4WIDTH+6 cycles.
- alu_op is held stable from k=1 to DONE. alu_ain, alu_bin and alu_rst change only in cycles where p=0 is being entered, so they are stable across both strobes.
- start outside IDLE (including the DONE cycle) is ignored, with no queueing.
- result and carry_out are cleared to 0 at accept. They are valid from the done cycle until the next accept.
- rst mid-operation: the next cycle is IDLE with every output 0, including result and carry_out. Any pending strobe is dropped.
- Exactly WIDTH+1 alu_reclk pulses and WIDTH+1 alu_feclk pulses occur per operation.

Decomposition:
- Shared package alu_pkg holds:
  - state typedef {IDLE, CLEAR, RUN, DONE};
  - phase constants PH_RE=0, PH_RL=1, PH_FE=2, PH_FL=3;
  - opcode constants, with OP_ADD=3'b000 (serial add, carry held in the ALU register).
- One sub-module, alu_phase_gen: the 2-bit phase counter and strobe decode. It has an enable input and a last-phase output.
- The state machine, operand shifters and result register stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with start=1. Required: all outputs 0, no strobes, and no accept until rst falls.
- Add with no final carry: opcode=000, a_in=8'h35, b_in=8'h0F, paired with the real alu. Required:
  - done at k=37 with result=8'h44 and carry_out=0;
  - 9 alu_reclk pulses and 9 alu_feclk pulses;
  - alu_rst high only for k=1..4.
- Add with carry out: a_in=8'hFF, b_in=8'h01. Required: result=8'h00, carry_out=1 at done.
- start while busy: accept 8'h35/8'h0F, then pulse start at k=10 with operands 8'hAA/8'h55. Required: exactly one done, at k=37, with result=8'h44.
- Reset mid-operation: assert rst at k=20. Required:
  - the next cycle has busy=0, result=0, all strobes 0;
  - a fresh start afterwards gives full 37-cycle latency and the correct sum.
- Back-to-back: start held high continuously. Required: accepts exactly every 38 cycles; done never coincides with busy; alu_reclk and alu_feclk are never high in the same cycle.
